// File: rtl/cache_types_pkg.sv
// cache_types_pkg: shared widths, beat index type and adapter FSM states
// for the cacheline burst adapter.
package cache_types_pkg;
    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int BEATS  = 4;
    typedef logic [1:0] beat_idx_t;
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} adapter_state_e;
endpackage

// File: rtl/burst_beat_counter.sv
// burst_beat_counter: 2-bit beat count that maps to a line slot
// by offsetting it with the burst's start beat.
module burst_beat_counter
    import cache_types_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       advance,
    input  logic [1:0] start_beat,
    output logic [1:0] beat_idx,
    output logic       last
);
    beat_idx_t r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_count <= '0;
        else if (clear)
            r_count <= '0;
        else if (advance)
            r_count <= r_count + 2'd1;
    end

    assign beat_idx = start_beat + r_count;
    assign last     = (r_count == 2'd3) && advance;
endmodule

// File: rtl/cacheline_burst_adapter.sv
// cacheline_burst_adapter: 256-bit line requests <-> four 64-bit bursts.
// CACHELINE_ADAPTER_CRITICAL_WORD_FIRST_EN starts bursts at the addressed beat and wraps.
module cacheline_burst_adapter
    import cache_types_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  line_address,
    output logic [255:0] line_rdata,
    input  logic [255:0] line_wdata,
    input  logic         line_read,
    input  logic         line_write,
    output logic         line_resp,
    output logic [31:0]  burst_address,
    input  logic [63:0]  burst_rdata,
    output logic [63:0]  burst_wdata,
    output logic         burst_read,
    output logic         burst_write,
    input  logic         burst_resp
);
    adapter_state_e    r_state;
    logic [LINE_W-1:0] r_line_buf;
    logic [LINE_W-1:0] r_wbuf;
    beat_idx_t         r_start_beat;
    beat_idx_t         w_beat_idx;
    beat_idx_t         w_start;
    logic [31:0]       w_base;
    logic              w_clear;
    logic              w_advance;
    logic              w_last;

`ifdef CACHELINE_ADAPTER_CRITICAL_WORD_FIRST_EN
    assign w_start = line_address[4:3];
    assign w_base  = line_address & ~32'h7;
`else
    assign w_start = '0;
    assign w_base  = line_address & ~32'h1F;
`endif

    assign w_clear     = (r_state == IDLE);
    assign w_advance   = burst_resp && (r_state == READ || r_state == WRITE);
    assign line_rdata  = r_line_buf;
    assign burst_wdata = r_wbuf[{w_beat_idx, 6'b0} +: BEAT_W];

    burst_beat_counter u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (w_clear),
        .advance    (w_advance),
        .start_beat (r_start_beat),
        .beat_idx   (w_beat_idx),
        .last       (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            line_resp     <= 1'b0;
            burst_read    <= 1'b0;
            burst_write   <= 1'b0;
            burst_address <= '0;
            r_wbuf        <= '0;
            r_line_buf    <= '0;
            r_start_beat  <= '0;
        end else begin
            line_resp <= 1'b0;
            case (r_state)
                IDLE: begin
                    // write has priority when a requester misbehaves and raises both
                    if (line_write) begin
                        r_state       <= WRITE;
                        burst_write   <= 1'b1;
                        burst_address <= w_base;
                        r_start_beat  <= w_start;
                        r_wbuf        <= line_wdata;
                    end else if (line_read) begin
                        r_state       <= READ;
                        burst_read    <= 1'b1;
                        burst_address <= w_base;
                        r_start_beat  <= w_start;
                    end
                end
                READ: begin
                    if (burst_resp)
                        r_line_buf[{w_beat_idx, 6'b0} +: BEAT_W] <= burst_rdata;
                    if (w_last) begin
                        r_state    <= DONE;
                        burst_read <= 1'b0;
                        line_resp  <= 1'b1;
                    end
                end
                WRITE: begin
                    if (w_last) begin
                        r_state     <= DONE;
                        burst_write <= 1'b0;
                        line_resp   <= 1'b1;
                    end
                end
                DONE: r_state <= IDLE;
            endcase
        end
    end

    a_single_request: assert property (@(posedge clk) disable iff (!rst_n)
        !(r_state == IDLE && line_read && line_write))
        else $warning("cacheline_burst_adapter: line_read and line_write both high in IDLE");
endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// tb_cacheline_burst_adapter: directed checks of line<->burst conversion,
// gapped responses, reset abort and back-to-back requests.
module tb_cacheline_burst_adapter;
    logic         clk;
    logic         rst_n;
    logic [31:0]  line_address;
    logic [255:0] line_rdata;
    logic [255:0] line_wdata;
    logic         line_read;
    logic         line_write;
    logic         line_resp;
    logic [31:0]  burst_address;
    logic [63:0]  burst_rdata;
    logic [63:0]  burst_wdata;
    logic         burst_read;
    logic         burst_write;
    logic         burst_resp;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] rseq [4];
    logic [63:0] wseq [4];
    logic saw_rd;
    int lat;

    cacheline_burst_adapter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .line_address  (line_address),
        .line_rdata    (line_rdata),
        .line_wdata    (line_wdata),
        .line_read     (line_read),
        .line_write    (line_write),
        .line_resp     (line_resp),
        .burst_address (burst_address),
        .burst_rdata   (burst_rdata),
        .burst_wdata   (burst_wdata),
        .burst_read    (burst_read),
        .burst_write   (burst_write),
        .burst_resp    (burst_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns in the cycle where line_resp is seen (lat = cycle number, request cycle = 1).
    task automatic do_req(input logic wr, input logic both, input logic [31:0] addr, input logic [31:0] exp_addr,
                          input logic [15:0] pat, input int plen, output int cyc);
        int i = 0;
        int n = 0;
        line_address = addr;
        line_wdata   = {wseq[3], wseq[2], wseq[1], wseq[0]};
        line_write   = wr;
        line_read    = !wr || both;
        cyc    = 1;
        saw_rd = 1'b0;
        while (cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            line_address = ~addr;
            line_wdata   = ~{wseq[3], wseq[2], wseq[1], wseq[0]};
            if (burst_read) saw_rd = 1'b1;
            if (line_resp) break;
            burst_resp = 1'b0;
            if (burst_read || burst_write) begin
                if (i == 0) chk("burst_addr", burst_address, exp_addr);
                if (burst_write && n < 4) chk("wbeat", burst_wdata, wseq[n]);
                burst_resp  = (i < plen) ? pat[i] : 1'b1;
                burst_rdata = rseq[n & 3];
                if (burst_resp) n++;
                i++;
            end
        end
        burst_resp = 1'b0;
        chk("line_resp", line_resp, 1);
        chk("burst_low", {burst_read, burst_write}, 0);
    endtask

    task automatic release_req;
        @(posedge clk); #1;
        line_read  = 1'b0;
        line_write = 1'b0;
        chk("resp_pulse", line_resp, 0);
    endtask

    initial begin
        rst_n = 1'b0; line_address = '0; line_wdata = '0; line_read = 1'b0;
        line_write = 1'b0; burst_rdata = '0; burst_resp = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("rst_resp", line_resp, 0);
        chk("rst_brd", burst_read, 0);
        chk("rst_bwr", burst_write, 0);
        chk("rst_addr", burst_address, 0);
        chk("rst_wdata", burst_wdata, 0);
        chk("rst_rdata", line_rdata, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        rseq = '{64'hA0A0_0000_0000_00A0, 64'hA1A1_0000_0000_00A1, 64'hA2A2_0000_0000_00A2, 64'hA3A3_0000_0000_00A3};
        wseq = '{64'h0, 64'h0, 64'h0, 64'h0};
        do_req(1'b0, 1'b0, 32'h0000_1040, 32'h0000_1040, 16'hFFFF, 0, lat);
        chk("rd_lat", lat, 6);
        chk("rd_line", line_rdata, {rseq[3], rseq[2], rseq[1], rseq[0]});
        release_req();

        wseq = '{64'hD0D0_1111_0000_00D0, 64'hD1D1_2222_0000_00D1, 64'hD2D2_3333_0000_00D2, 64'hD3D3_4444_0000_00D3};
        do_req(1'b1, 1'b0, 32'h0000_2000, 32'h0000_2000, 16'h0059, 7, lat);
        chk("wr_gap_lat", lat, 9);
        release_req();

        rseq = '{64'hB0B0_0000_0000_00B0, 64'hB1B1_0000_0000_00B1, 64'hB2B2_0000_0000_00B2, 64'hB3B3_0000_0000_00B3};
`ifdef CACHELINE_ADAPTER_CRITICAL_WORD_FIRST_EN
        do_req(1'b0, 1'b0, 32'h0000_1058, 32'h0000_1058, 16'hFFFF, 0, lat);
        chk("cwf_line", line_rdata, {rseq[0], rseq[3], rseq[2], rseq[1]});
`else
        do_req(1'b0, 1'b0, 32'h0000_1058, 32'h0000_1040, 16'hFFFF, 0, lat);
        chk("cwf_line", line_rdata, {rseq[3], rseq[2], rseq[1], rseq[0]});
`endif
        release_req();

        wseq = '{64'hF0F0_0000_0000_00F0, 64'hF1F1_0000_0000_00F1, 64'hF2F2_0000_0000_00F2, 64'hF3F3_0000_0000_00F3};
        do_req(1'b1, 1'b1, 32'h0000_3000, 32'h0000_3000, 16'hFFFF, 0, lat);
        chk("both_no_read", saw_rd, 0);
        chk("both_lat", lat, 6);
        release_req();

        rseq = '{64'hC0C0_0000_0000_00C0, 64'hC1C1_0000_0000_00C1, 64'hC2C2_0000_0000_00C2, 64'hC3C3_0000_0000_00C3};
        @(posedge clk); #1;
        line_address = 32'h0000_4000;
        line_read    = 1'b1;
        @(posedge clk); #1;
        burst_resp  = 1'b1;
        burst_rdata = rseq[0];
        @(posedge clk); #1;
        burst_rdata = rseq[1];
        @(posedge clk); #1;
        burst_resp = 1'b0;
        line_read  = 1'b0;
        chk("pre_rst_brd", burst_read, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_brd", burst_read, 0);
        chk("arst_addr", burst_address, 0);
        chk("arst_rdata", line_rdata, 0);
        chk("arst_wdata", burst_wdata, 0);
        chk("arst_resp", line_resp, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        do_req(1'b0, 1'b0, 32'h0000_4000, 32'h0000_4000, 16'hFFFF, 0, lat);
        chk("post_rst_lat", lat, 6);
        chk("post_rst_line", line_rdata, {rseq[3], rseq[2], rseq[1], rseq[0]});
        release_req();

        wseq = '{64'hE0E0_5555_0000_00E0, 64'hE1E1_6666_0000_00E1, 64'hE2E2_7777_0000_00E2, 64'hE3E3_8888_0000_00E3};
        do_req(1'b1, 1'b0, 32'h0000_5000, 32'h0000_5000, 16'hFFFF, 0, lat);
        release_req();
        @(posedge clk); #1;
        rseq = wseq;
        do_req(1'b0, 1'b0, 32'h0000_5000, 32'h0000_5000, 16'hFFFF, 0, lat);
        chk("b2b_lat", lat, 6);
        chk("b2b_line", line_rdata, {wseq[3], wseq[2], wseq[1], wseq[0]});
        release_req();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
